// File: rtl/mmio_pkg.sv
// Shared address map for the MMIO bridge: the 4-bit page prefix that selects
// the peripheral window and the individual register addresses inside it.
package mmio_pkg;

   localparam logic [3:0]  MMIO_PREFIX = 4'hF;
   localparam logic [11:0] KEY_DATA    = 12'hF00;
   localparam logic [11:0] KEY_STAT    = 12'hF01;
   localparam logic [11:0] DROP_CNT    = 12'hF02;
   localparam logic [11:0] SPRITE_BASE = 12'hF10;

   localparam int KEY_W = 4;

endpackage

// File: rtl/mmio_key_fifo.sv
// Controller key event FIFO. Power-of-two depth so the pointers wrap for
// free; push is refused while full and pop is ignored while empty, so the
// caller may assert either strobe unconditionally. No same-cycle bypass:
// a full FIFO stays full for the cycle in which it is popped.
module mmio_key_fifo
   import mmio_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clock_i,
   input  logic             resetN_i,
   input  logic             push_i,
   input  logic [KEY_W-1:0] pushCode_i,
   input  logic             pop_i,
   output logic [KEY_W-1:0] headCode_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [KEY_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             doPush, doPop;

   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign headCode_o = mem_q[rdPtr_q];
   assign doPush     = resetN_i && push_i && !full_o;
   assign doPop      = resetN_i && pop_i && !empty_o;

   // Next pointer and occupancy values; push and pop together leave count alone
   always_comb begin
      wrPtr_d = wrPtr_q + AW'(doPush);
      rdPtr_d = rdPtr_q + AW'(doPop);
      count_d = count_q;
      case ({doPush, doPop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers, cleared by the synchronous active-low reset
   always_ff @(posedge clock_i) begin
      if (!resetN_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage array; contents are meaningless while empty so it needs no reset
   always_ff @(posedge clock_i) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushCode_i;
      end
   end

endmodule

// File: rtl/mmio_bridge.sv
// Data-memory MMIO bridge. Page 0xF of the 12-bit data address space is
// decoded locally (key FIFO, status, sprite position registers); every
// other address is passed straight through to the data RAM.
// Optional feature: define MMIO_DROP_CNT_EN to build a saturating counter of
// key events refused because the FIFO was full, readable at 0xF02.
module mmio_bridge
   import mmio_pkg::*;
#(
   parameter  int FIFO_DEPTH = 8,
   parameter  int SPRITES    = 8,
   localparam int IDXW       = (SPRITES > 1) ? $clog2(SPRITES) : 1,
   localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [11:0]      address_dmem,
   input  logic [31:0]      data,
   input  logic             wren,
   input  logic             rden,
   output logic [31:0]      q_dmem,
   output logic [11:0]      ram_address,
   output logic [31:0]      ram_data,
   output logic             ram_wren,
   input  logic [31:0]      ram_q,
   input  logic             btn_valid,
   input  logic [KEY_W-1:0] btn_code,
   output logic             btn_ready,
   input  logic [IDXW-1:0]  vga_idx,
   output logic [31:0]      vga_pos
);

   localparam logic [4:0] SPRITE_LIMIT = 5'(SPRITES);

   logic             isMmio, isKeyData, isKeyStat, spriteHit;
   logic             fifoFull, fifoEmpty, fifoPop;
   logic [KEY_W-1:0] fifoHead;
   logic [CW-1:0]    fifoCount;
   logic [31:0]      dropValue;
   logic [31:0]      sprite_q [16];
   logic [4:0]       vgaIdxExt;

   assign isMmio    = (address_dmem[11:8] == MMIO_PREFIX);
   assign isKeyData = (address_dmem == KEY_DATA);
   assign isKeyStat = (address_dmem == KEY_STAT);
   assign spriteHit = isMmio && (address_dmem[7:4] == SPRITE_BASE[7:4])
                      && ({1'b0, address_dmem[3:0]} < SPRITE_LIMIT);

   assign ram_address = address_dmem;
   assign ram_data    = data;
   assign ram_wren    = wren && !isMmio;

   assign btn_ready = reset && !fifoFull;
   assign fifoPop   = rden && isKeyData;

   mmio_key_fifo #(.DEPTH(FIFO_DEPTH)) u_keyFifo (
      .clock_i    (clock),
      .resetN_i   (reset),
      .push_i     (btn_valid),
      .pushCode_i (btn_code),
      .pop_i      (fifoPop),
      .headCode_o (fifoHead),
      .count_o    (fifoCount),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty)
   );

   // Sprite position registers; only indices below SPRITES are ever written
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            sprite_q[i] <= '0;
         end
      end else if (wren && spriteHit) begin
         sprite_q[address_dmem[3:0]] <= data;
      end
   end

`ifdef MMIO_DROP_CNT_EN
   logic [15:0] dropCnt_q;

   // Count cycles in which an offered key event was refused, saturating at max
   always_ff @(posedge clock) begin
      if (!reset) begin
         dropCnt_q <= '0;
      end else if (btn_valid && fifoFull && (dropCnt_q != 16'hFFFF)) begin
         dropCnt_q <= dropCnt_q + 16'd1;
      end
   end

   assign dropValue = {16'b0, dropCnt_q};
`else
   assign dropValue = '0;
`endif

   // Display-side read port; the registered array gives old-value-on-write
   always_comb begin
      vgaIdxExt = 5'(vga_idx);
      vga_pos   = '0;
      if (vgaIdxExt < SPRITE_LIMIT) begin
         vga_pos = sprite_q[vgaIdxExt[3:0]];
      end
   end

   // Load data mux: RAM data outside the MMIO page, decoded registers inside
   always_comb begin
      q_dmem = '0;
      if (!isMmio) begin
         q_dmem = ram_q;
      end else if (isKeyData) begin
         q_dmem = {27'b0, !fifoEmpty, fifoEmpty ? 4'b0 : fifoHead};
      end else if (isKeyStat) begin
         q_dmem = 32'(fifoCount);
      end else if (address_dmem == DROP_CNT) begin
         q_dmem = dropValue;
      end else if (spriteHit) begin
         q_dmem = sprite_q[address_dmem[3:0]];
      end
   end

endmodule
